// File: rtl/monster_queue_if.sv
// Bundles the game-facing signals of monster_queue.
//   master: game controller / testbench side (drives start, btn, random feed, rd_idx)
//   slave : monster_queue side (drives need_random, rd_type, score, misses, hit, miss, gameover)
interface monster_queue_if #(
  parameter int unsigned LANES      = 3,
  parameter int unsigned DEPTH      = 6,
  parameter int unsigned TYPE_W     = 2,
  parameter int unsigned MISS_LIMIT = 3,
  parameter int unsigned SCORE_W    = 8
);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

  logic               start;
  logic [LANES-1:0]   btn;
  logic               rand_valid;
  logic [TYPE_W-1:0]  rand_type;
  logic               need_random;
  logic [IDX_W-1:0]   rd_idx;
  logic [TYPE_W-1:0]  rd_type;
  logic [SCORE_W-1:0] score;
  logic [MISS_W-1:0]  misses;
  logic               hit;
  logic               miss;
  logic               gameover;

  modport master (
    output start, btn, rand_valid, rand_type, rd_idx,
    input  need_random, rd_type, score, misses, hit, miss, gameover
  );

  modport slave (
    input  start, btn, rand_valid, rand_type, rd_idx,
    output need_random, rd_type, score, misses, hit, miss, gameover
  );
endinterface

// File: rtl/monster_queue.sv
// Monster-punching game queue. A DEPTH-slot queue of monster codes (0 = empty,
// k = monster beaten by button k-1) is filled from a random source, then the
// player punches the front monster. Correct punches score and shift the queue,
// wrong punches (or an optional front-monster timeout) count misses; MISS_LIMIT
// misses end the game.
// Ports:
//   clk - clock
//   rst - asynchronous active-high reset
//   bus - monster_queue_if.slave: start, btn, random feed (rand_valid/rand_type,
//         need_random), renderer read (rd_idx/rd_type), score, misses, hit/miss
//         pulses, gameover
module monster_queue #(
  parameter int unsigned LANES      = 3,
  parameter int unsigned DEPTH      = 6,
  parameter int unsigned TYPE_W     = 2,
  parameter int unsigned MISS_LIMIT = 3,
  parameter int unsigned TIMEOUT    = 0,
  parameter int unsigned SCORE_W    = 8
) (
  input logic           clk,
  input logic           rst,
  monster_queue_if.slave bus
);
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MISS_W  = $clog2(MISS_LIMIT + 1);
  localparam int unsigned AGE_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned AGE_MAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {StIdle, StFill, StPlay, StOver} state_e;

  state_e             state_q;
  logic [TYPE_W-1:0]  slot_q [DEPTH];
  logic [IDX_W-1:0]   fill_cnt_q;
  logic [SCORE_W-1:0] score_q;
  logic [MISS_W-1:0]  misses_q;
  logic [AGE_W-1:0]   age_q;
  logic               hit_q;
  logic               miss_q;

  logic [TYPE_W-1:0] front;
  logic [TYPE_W-1:0] rand_code;
  logic [LANES-1:0]  want_btn;
  logic              front_full;
  logic              btn_hit;
  logic              btn_miss;
  logic              timeout;
  logic              limit_hit;
  logic              play_active;
  logic              shift;
  logic              tail_empty;
  logic              take_rand;

  always_comb begin
    front      = slot_q[0];
    front_full = (front != '0);
    want_btn   = '0;
    if (front_full) want_btn = LANES'(1) << (front - 1'b1);
    // Exact match against the one-hot lane also rejects multi-bit presses.
    btn_hit    = front_full && (bus.btn == want_btn);
    btn_miss   = front_full && (bus.btn != '0) && !btn_hit;
    // Any button press pre-empts the timeout in the same cycle.
    timeout    = (TIMEOUT != 0) && front_full && (bus.btn == '0) &&
                 (age_q == AGE_W'(AGE_MAX));
    limit_hit   = (misses_q == MISS_W'(MISS_LIMIT));
    play_active = (state_q == StPlay) && !limit_hit;
    shift       = play_active && (btn_hit || timeout);
    tail_empty  = (slot_q[DEPTH-1] == '0);
    // A shift vacates the tail, so a code offered alongside it is always taken.
    take_rand   = play_active && bus.rand_valid && (tail_empty || shift);
    if ((bus.rand_type == '0) || (32'(bus.rand_type) > LANES)) rand_code = TYPE_W'(1);
    else                                                       rand_code = bus.rand_type;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fill_cnt_q <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      age_q      <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= '0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      unique case (state_q)
        StIdle, StOver: begin
          if (bus.start) begin
            state_q    <= StFill;
            fill_cnt_q <= '0;
            score_q    <= '0;
            misses_q   <= '0;
            age_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= '0;
          end
        end
        StFill: begin
          if (bus.rand_valid) begin
            slot_q[fill_cnt_q] <= rand_code;
            fill_cnt_q         <= fill_cnt_q + 1'b1;
            if (fill_cnt_q == IDX_W'(DEPTH - 1)) state_q <= StPlay;
          end
        end
        StPlay: begin
          if (limit_hit) begin
            state_q <= StOver;
            for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= '0;
          end else begin
            if (shift) begin
              for (int i = 0; i < int'(DEPTH) - 1; i++) slot_q[i] <= slot_q[i+1];
              slot_q[DEPTH-1] <= take_rand ? rand_code : '0;
            end else if (take_rand) begin
              slot_q[DEPTH-1] <= rand_code;
            end
            if (btn_hit) begin
              hit_q <= 1'b1;
              if (score_q != '1) score_q <= score_q + 1'b1;
            end
            if (btn_miss || timeout) begin
              miss_q   <= 1'b1;
              misses_q <= misses_q + 1'b1;
            end
            // Age saturates so a timeout pre-empted by a wrong press fires later.
            if (shift || !front_full)        age_q <= '0;
            else if (age_q != AGE_W'(AGE_MAX)) age_q <= age_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.need_random = (state_q == StFill) || ((state_q == StPlay) && tail_empty);
  assign bus.rd_type     = (32'(bus.rd_idx) < DEPTH) ? slot_q[bus.rd_idx] : '0;
  assign bus.score       = score_q;
  assign bus.misses      = misses_q;
  assign bus.hit         = hit_q;
  assign bus.miss        = miss_q;
  assign bus.gameover    = (state_q == StOver);
endmodule

// File: tb/tb_monster_queue.sv
`timescale 1ns/1ps
module tb_monster_queue;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  monster_queue_if ifa ();
  monster_queue_if ifb ();

  monster_queue #(.TIMEOUT(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  monster_queue #(.TIMEOUT(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_a(input int idx, output logic [1:0] v);
    ifa.rd_idx = 3'(idx);
    #1;
    v = ifa.rd_type;
  endtask

  task automatic read_b(input int idx, output logic [1:0] v);
    ifb.rd_idx = 3'(idx);
    #1;
    v = ifb.rd_type;
  endtask

  task automatic test_reset();
    logic [1:0] v;
    rst = 1'b0;
    #2 rst = 1'b1;
    #2;
    read_a(0, v);
    checks++; if (v !== 2'd0) begin failures++; $display("FAIL reset_slot0 got=%0d want=0", v); end
    checks++; if (ifa.need_random !== 1'b0) begin failures++; $display("FAIL reset_need_random got=%b want=0", ifa.need_random); end
    checks++; if (ifa.score !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d want=0", ifa.score); end
    checks++; if (ifa.misses !== 2'd0) begin failures++; $display("FAIL reset_misses got=%0d want=0", ifa.misses); end
    checks++; if ({ifa.hit, ifa.miss, ifa.gameover} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b want=000", {ifa.hit, ifa.miss, ifa.gameover}); end
    checks++; if (ifb.gameover !== 1'b0 || ifb.need_random !== 1'b0) begin failures++; $display("FAIL reset_b got=%b%b want=00", ifb.gameover, ifb.need_random); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    logic [1:0] v;
    logic [1:0] exp [6];
    exp = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    checks++; if (ifa.need_random !== 1'b1) begin failures++; $display("FAIL fill_need_random got=%b want=1", ifa.need_random); end
    for (int i = 0; i < 6; i++) begin
      ifa.rand_valid = 1'b1;
      ifa.rand_type  = exp[i];
      step();
    end
    ifa.rand_valid = 1'b0;
    checks++; if (ifa.need_random !== 1'b0) begin failures++; $display("FAIL play_need_random got=%b want=0", ifa.need_random); end
    for (int i = 0; i < 6; i++) begin
      read_a(i, v);
      checks++; if (v !== exp[i]) begin failures++; $display("FAIL fill_slot%0d got=%0d want=%0d", i, v, exp[i]); end
    end
    read_a(6, v);
    checks++; if (v !== 2'd0) begin failures++; $display("FAIL rd_idx6 got=%0d want=0", v); end
    read_a(7, v);
    checks++; if (v !== 2'd0) begin failures++; $display("FAIL rd_idx7 got=%0d want=0", v); end
  endtask

  // Queue 1,2,3,1,2,3 -> hit -> 2,3,1,2,3,0 -> refill 3
  task automatic test_hit_refill();
    logic [1:0] v;
    ifa.btn = 3'b001;
    step();
    ifa.btn = 3'b000;
    checks++; if (ifa.hit !== 1'b1 || ifa.miss !== 1'b0) begin failures++; $display("FAIL hit_pulse got=%b%b want=10", ifa.hit, ifa.miss); end
    checks++; if (ifa.score !== 8'd1) begin failures++; $display("FAIL hit_score got=%0d want=1", ifa.score); end
    read_a(0, v);
    checks++; if (v !== 2'd2) begin failures++; $display("FAIL hit_slot0 got=%0d want=2", v); end
    read_a(5, v);
    checks++; if (v !== 2'd0) begin failures++; $display("FAIL hit_slot5 got=%0d want=0", v); end
    checks++; if (ifa.need_random !== 1'b1) begin failures++; $display("FAIL hit_need_random got=%b want=1", ifa.need_random); end
    ifa.rand_valid = 1'b1;
    ifa.rand_type  = 2'd3;
    step();
    ifa.rand_valid = 1'b0;
    read_a(5, v);
    checks++; if (v !== 2'd3) begin failures++; $display("FAIL refill_slot5 got=%0d want=3", v); end
    checks++; if (ifa.hit !== 1'b0) begin failures++; $display("FAIL hit_one_cycle got=%b want=0", ifa.hit); end
    checks++; if (ifa.need_random !== 1'b0) begin failures++; $display("FAIL refill_need_random got=%b want=0", ifa.need_random); end
  endtask

  // Queue 2,3,1,2,3,3 -> hit with code 0 offered -> 3,1,2,3,3,1
  task automatic test_hit_with_rand();
    logic [1:0] v;
    ifa.btn        = 3'b010;
    ifa.rand_valid = 1'b1;
    ifa.rand_type  = 2'd0;
    step();
    ifa.btn        = 3'b000;
    ifa.rand_valid = 1'b0;
    read_a(5, v);
    checks++; if (v !== 2'd1) begin failures++; $display("FAIL hitrand_slot5 got=%0d want=1", v); end
    read_a(0, v);
    checks++; if (v !== 2'd3) begin failures++; $display("FAIL hitrand_slot0 got=%0d want=3", v); end
    checks++; if (ifa.score !== 8'd2) begin failures++; $display("FAIL hitrand_score got=%0d want=2", ifa.score); end
  endtask

  task automatic test_ignored_inputs();
    logic [1:0] v;
    // Tail full: rand_valid ignored. start in PLAY ignored.
    ifa.rand_valid = 1'b1;
    ifa.rand_type  = 2'd2;
    ifa.start      = 1'b1;
    step();
    ifa.rand_valid = 1'b0;
    ifa.start      = 1'b0;
    read_a(5, v);
    checks++; if (v !== 2'd1) begin failures++; $display("FAIL full_tail_slot5 got=%0d want=1", v); end
    read_a(4, v);
    checks++; if (v !== 2'd3) begin failures++; $display("FAIL full_tail_slot4 got=%0d want=3", v); end
    checks++; if (ifa.score !== 8'd2) begin failures++; $display("FAIL start_in_play_score got=%0d want=2", ifa.score); end
  endtask

  // Front is 3 (button 100): 001 wrong lane, 011 and 110 multi-bit.
  task automatic test_misses_gameover();
    logic [1:0] v;
    logic [2:0] presses [3];
    presses = '{3'b001, 3'b011, 3'b110};
    for (int k = 0; k < 3; k++) begin
      ifa.btn = presses[k];
      step();
      ifa.btn = 3'b000;
      checks++; if (ifa.miss !== 1'b1 || ifa.hit !== 1'b0) begin failures++; $display("FAIL miss%0d_pulse got=%b%b want=01", k, ifa.miss, ifa.hit); end
      checks++; if (ifa.misses !== 2'(k + 1)) begin failures++; $display("FAIL miss%0d_count got=%0d want=%0d", k, ifa.misses, k + 1); end
      read_a(0, v);
      checks++; if (v !== 2'd3) begin failures++; $display("FAIL miss%0d_front got=%0d want=3", k, v); end
    end
    checks++; if (ifa.gameover !== 1'b0) begin failures++; $display("FAIL gameover_early got=%b want=0", ifa.gameover); end
    step();
    checks++; if (ifa.gameover !== 1'b1) begin failures++; $display("FAIL gameover got=%b want=1", ifa.gameover); end
    checks++; if (ifa.score !== 8'd2) begin failures++; $display("FAIL over_score got=%0d want=2", ifa.score); end
    checks++; if (ifa.need_random !== 1'b0) begin failures++; $display("FAIL over_need_random got=%b want=0", ifa.need_random); end
    for (int i = 0; i < 6; i++) begin
      read_a(i, v);
      checks++; if (v !== 2'd0) begin failures++; $display("FAIL over_slot%0d got=%0d want=0", i, v); end
    end
    ifa.btn = 3'b100;
    step();
    ifa.btn = 3'b000;
    checks++; if (ifa.misses !== 2'd3 || ifa.miss !== 1'b0) begin failures++; $display("FAIL over_btn got=%0d/%b want=3/0", ifa.misses, ifa.miss); end
  endtask

  // Restart, fill 2,1,3,3,1,2 (a button during FILL is ignored), then 5 hits.
  task automatic test_restart();
    logic [1:0] codes [6];
    logic [2:0] hits  [5];
    codes = '{2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2};
    hits  = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b001};
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    checks++; if (ifa.need_random !== 1'b1 || ifa.gameover !== 1'b0) begin failures++; $display("FAIL restart_state got=%b%b want=10", ifa.need_random, ifa.gameover); end
    checks++; if (ifa.score !== 8'd0 || ifa.misses !== 2'd0) begin failures++; $display("FAIL restart_counts got=%0d/%0d want=0/0", ifa.score, ifa.misses); end
    for (int i = 0; i < 6; i++) begin
      ifa.rand_valid = 1'b1;
      ifa.rand_type  = codes[i];
      ifa.btn        = (i == 2) ? 3'b001 : 3'b000;
      step();
    end
    ifa.rand_valid = 1'b0;
    ifa.btn        = 3'b000;
    checks++; if (ifa.misses !== 2'd0 || ifa.miss !== 1'b0) begin failures++; $display("FAIL fill_btn_ignored got=%0d want=0", ifa.misses); end
    for (int i = 0; i < 5; i++) begin
      ifa.btn = hits[i];
      step();
    end
    ifa.btn = 3'b000;
    checks++; if (ifa.score !== 8'd5) begin failures++; $display("FAIL five_hits_score got=%0d want=5", ifa.score); end
  endtask

  task automatic test_async_reset();
    logic [1:0] v;
    #3 rst = 1'b1;
    #1;
    checks++; if (ifa.score !== 8'd0) begin failures++; $display("FAIL async_score got=%0d want=0", ifa.score); end
    checks++; if (ifa.need_random !== 1'b0 || ifa.gameover !== 1'b0) begin failures++; $display("FAIL async_flags got=%b%b want=00", ifa.need_random, ifa.gameover); end
    read_a(0, v);
    checks++; if (v !== 2'd0) begin failures++; $display("FAIL async_slot0 got=%0d want=0", v); end
    step();
    rst = 1'b0;
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    checks++; if (ifa.need_random !== 1'b1) begin failures++; $display("FAIL async_restart got=%b want=1", ifa.need_random); end
  endtask

  task automatic test_timeout();
    logic [1:0] v;
    logic [1:0] codes [6];
    codes = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ifb.rand_valid = 1'b1;
      ifb.rand_type  = codes[i];
      step();
    end
    ifb.rand_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++; if (ifb.miss !== 1'b0) begin failures++; $display("FAIL timeout_early%0d got=%b want=0", c, ifb.miss); end
    end
    step();
    checks++; if (ifb.miss !== 1'b1 || ifb.misses !== 2'd1) begin failures++; $display("FAIL timeout_miss got=%b/%0d want=1/1", ifb.miss, ifb.misses); end
    read_b(0, v);
    checks++; if (v !== 2'd2) begin failures++; $display("FAIL timeout_front got=%0d want=2", v); end
    checks++; if (ifb.score !== 8'd0) begin failures++; $display("FAIL timeout_score got=%0d want=0", ifb.score); end
    // Correct press coincident with the next timeout: hit wins.
    for (int c = 0; c < 3; c++) step();
    ifb.btn = 3'b010;
    step();
    ifb.btn = 3'b000;
    checks++; if (ifb.hit !== 1'b1 || ifb.miss !== 1'b0) begin failures++; $display("FAIL prio_pulse got=%b%b want=10", ifb.hit, ifb.miss); end
    checks++; if (ifb.misses !== 2'd1 || ifb.score !== 8'd1) begin failures++; $display("FAIL prio_counts got=%0d/%0d want=1/1", ifb.misses, ifb.score); end
    read_b(0, v);
    checks++; if (v !== 2'd3) begin failures++; $display("FAIL prio_front got=%0d want=3", v); end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    ifa.start      = 1'b0;
    ifa.btn        = '0;
    ifa.rand_valid = 1'b0;
    ifa.rand_type  = '0;
    ifa.rd_idx     = '0;
    ifb.start      = 1'b0;
    ifb.btn        = '0;
    ifb.rand_valid = 1'b0;
    ifb.rand_type  = '0;
    ifb.rd_idx     = '0;
    test_reset();
    test_fill();
    test_hit_refill();
    test_hit_with_rand();
    test_ignored_inputs();
    test_misses_gameover();
    test_restart();
    test_async_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
